// File: rtl/opl2_pkg.sv
// Shared types, widths and helpers for the OPL2 operator/mixer pipeline.
package opl2_pkg;

    localparam int OP_NUM_WIDTH               = 5;
    localparam int OP_OUT_WIDTH               = 13;
    localparam int NUM_OPERATORS              = 18;
    localparam int CHANNEL_MIXER_ACC_WIDTH    = 18;
    localparam int CHANNEL_MIXER_SAMPLE_WIDTH = 16;

    typedef struct packed {
        logic       valid;
        logic [7:0] address;
        logic [7:0] data;
    } opl2_reg_wr_t;

    typedef struct packed {
        logic                           valid;
        logic [OP_NUM_WIDTH-1:0]        op_num;
        logic signed [OP_OUT_WIDTH-1:0] op_out;
    } operator_out_t;

    typedef enum logic [1:0] {
        ACCUM,
        DRAIN,
        EMIT
    } channel_mixer_state_t;

    // Operators come in groups of six: three modulators then their three carriers.
    function automatic logic [3:0] op_num_to_channel(input logic [OP_NUM_WIDTH-1:0] op_num);
        logic [OP_NUM_WIDTH-1:0] slot;
        logic [OP_NUM_WIDTH-1:0] group;
        slot  = op_num % OP_NUM_WIDTH'(3);
        group = op_num / OP_NUM_WIDTH'(6);
        return 4'(slot + OP_NUM_WIDTH'(3) * group);
    endfunction

    function automatic logic op_is_modulator(input logic [OP_NUM_WIDTH-1:0] op_num);
        return (op_num % OP_NUM_WIDTH'(6)) < OP_NUM_WIDTH'(3);
    endfunction

endpackage

// File: rtl/channel_mixer_saturate.sv
// Signed clamp from IN_WIDTH down to OUT_WIDTH bits.
module channel_mixer_saturate #(
    parameter int IN_WIDTH  = 19,
    parameter int OUT_WIDTH = 16
) (
    input  logic signed [IN_WIDTH-1:0]  data_in,
    output logic signed [OUT_WIDTH-1:0] data_out
);

    localparam int HEAD_WIDTH = IN_WIDTH - OUT_WIDTH + 1;

    logic [HEAD_WIDTH-1:0] head;

    assign head = data_in[IN_WIDTH-1:OUT_WIDTH-1];

    // In range exactly when every bit above the output sign bit copies it.
    always_comb begin
        data_out = data_in[OUT_WIDTH-1:0];
        if (head != {HEAD_WIDTH{1'b0}} && head != {HEAD_WIDTH{1'b1}}) begin
            data_out = data_in[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                           : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/channel_mixer.sv
// Mixes the time-multiplexed operator stream into one saturated sample per frame
// and hands it to the output stage over a valid/ready handshake.
module channel_mixer
    import opl2_pkg::*;
#(
    parameter int ACC_WIDTH    = CHANNEL_MIXER_ACC_WIDTH,
    parameter int GAIN_SHIFT   = 1,
    parameter int SAMPLE_WIDTH = CHANNEL_MIXER_SAMPLE_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  opl2_reg_wr_t                   opl2_reg_wr,
    input  logic                           ryt,
    input  operator_out_t                  operator_out,
    input  logic                           ops_done_pulse,
    output logic signed [SAMPLE_WIDTH-1:0] sample,
    output logic                           sample_valid,
    input  logic                           sample_ready,
    output logic                           overrun
);

    localparam int SCALED_WIDTH = ACC_WIDTH + GAIN_SHIFT;
    localparam logic [OP_NUM_WIDTH-1:0] LAST_OP        = OP_NUM_WIDTH'(NUM_OPERATORS - 1);
    localparam logic [OP_NUM_WIDTH-1:0] RHYTHM_BASE_OP = OP_NUM_WIDTH'(12);

    channel_mixer_state_t state, next_state;
    logic                        emit;
    logic [8:0]                  cnt;
    logic                        s1_valid;
    logic signed [ACC_WIDTH-1:0] s1_contrib;
    logic                        defer_valid;
    logic signed [ACC_WIDTH-1:0] defer_contrib;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] op_ext;
    logic signed [ACC_WIDTH-1:0] contrib;
    logic signed [ACC_WIDTH-1:0] s1_term;
    logic signed [ACC_WIDTH-1:0] defer_term;
    logic signed [SCALED_WIDTH-1:0] scaled;
    logic signed [SAMPLE_WIDTH-1:0] saturated;
    logic                        unused_data;

    assign unused_data = ^opl2_reg_wr.data[7:1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (opl2_reg_wr.valid && opl2_reg_wr.address[7:4] == 4'hC
                     && opl2_reg_wr.address[3:0] <= 4'd8) begin
            cnt[opl2_reg_wr.address[3:0]] <= opl2_reg_wr.data[0];
        end
    end

    assign op_ext = {{(ACC_WIDTH-OP_OUT_WIDTH){operator_out.op_out[OP_OUT_WIDTH-1]}},
                     operator_out.op_out};

    // Percussion operators bypass the connection bit; op12 is silenced in rhythm mode.
    always_comb begin
        contrib = '0;
        if (operator_out.op_num <= LAST_OP) begin
            if (ryt && operator_out.op_num >= RHYTHM_BASE_OP) begin
                if (operator_out.op_num != RHYTHM_BASE_OP) begin
                    contrib = op_ext <<< 1;
                end
            end else if (!op_is_modulator(operator_out.op_num)
                         || cnt[op_num_to_channel(operator_out.op_num)]) begin
                contrib = op_ext;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid   <= 1'b0;
            s1_contrib <= '0;
        end else begin
            s1_valid <= operator_out.valid;
            if (operator_out.valid) begin
                s1_contrib <= contrib;
            end
        end
    end

    assign s1_term    = s1_valid    ? s1_contrib    : '0;
    assign defer_term = defer_valid ? defer_contrib : '0;

    // A contribution arriving while the frame is cleared is parked for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc           <= '0;
            defer_valid   <= 1'b0;
            defer_contrib <= '0;
        end else if (emit) begin
            acc           <= '0;
            defer_valid   <= s1_valid;
            defer_contrib <= s1_contrib;
        end else begin
            acc         <= acc + s1_term + defer_term;
            defer_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        emit       = 1'b0;
        case (state)
            ACCUM: if (ops_done_pulse) next_state = DRAIN;
            DRAIN: next_state = EMIT;
            EMIT: begin
                next_state = ACCUM;
                emit       = 1'b1;
            end
            default: next_state = ACCUM;
        endcase
    end

    assign scaled = SCALED_WIDTH'(acc) <<< GAIN_SHIFT;

    channel_mixer_saturate #(
        .IN_WIDTH (SCALED_WIDTH),
        .OUT_WIDTH(SAMPLE_WIDTH)
    ) u_saturate (
        .data_in (scaled),
        .data_out(saturated)
    );

    // A new sample replaces one still waiting downstream and flags the loss.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample       <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (emit) begin
            sample       <= saturated;
            sample_valid <= 1'b1;
            if (sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_channel_mixer.sv
// Bench for channel_mixer: directed scenarios plus randomized frames compared
// against a channel-level reference model.
module tb_channel_mixer;
    import opl2_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    opl2_reg_wr_t       opl2_reg_wr;
    logic               ryt;
    operator_out_t      operator_out;
    logic               ops_done_pulse;
    logic signed [15:0] sample;
    logic               sample_valid;
    logic               sample_ready;
    logic               overrun;

    int vectors     = 0;
    int miscompares = 0;
    int frame_vals[18];
    bit model_cnt[9];

    channel_mixer #(
        .ACC_WIDTH   (18),
        .GAIN_SHIFT  (1),
        .SAMPLE_WIDTH(16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .opl2_reg_wr   (opl2_reg_wr),
        .ryt           (ryt),
        .operator_out  (operator_out),
        .ops_done_pulse(ops_done_pulse),
        .sample        (sample),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic signed [31:0] observed,
                         input logic signed [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic clear_frame();
        foreach (frame_vals[i]) frame_vals[i] = 0;
    endtask

    // Operator values are presented one per cycle; the caller ends the burst.
    task automatic drive_op(input int op, input int val);
        operator_out.valid  = 1'b1;
        operator_out.op_num = 5'(op);
        operator_out.op_out = 13'(val);
        frame_vals[op] += val;
        @(negedge clk);
    endtask

    task automatic write_reg(input logic [7:0] addr, input logic [7:0] data);
        opl2_reg_wr.valid   = 1'b1;
        opl2_reg_wr.address = addr;
        opl2_reg_wr.data    = data;
        @(negedge clk);
        opl2_reg_wr.valid = 1'b0;
        if (addr >= 8'hC0 && addr <= 8'hC8) model_cnt[int'(addr) - 'hC0] = data[0];
    endtask

    task automatic pulse_done();
        operator_out.valid = 1'b0;
        ops_done_pulse     = 1'b1;
        @(negedge clk);
        ops_done_pulse = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 1;
        while (sample_valid !== 1'b1 && k < 12) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic finish_frame(input string tag, input int expected);
        int k;
        pulse_done();
        wait_valid(k);
        check({tag, " latency"}, k, 3);
        check({tag, " sample"}, sample, expected);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        check({tag, " valid drop"}, sample_valid, 0);
    endtask

    // Reference: sum each channel's audible operators, then gain x2 and clamp.
    function automatic int model_sample();
        int sum = 0;
        int mod_op;
        int car_op;
        int s;
        for (int ch = 0; ch < 9; ch++) begin
            mod_op = (ch % 3) + 6 * (ch / 3);
            car_op = mod_op + 3;
            if (ryt && ch == 6) sum += 2 * frame_vals[car_op];
            else if (ryt && ch > 6) sum += 2 * (frame_vals[mod_op] + frame_vals[car_op]);
            else sum += frame_vals[car_op] + (model_cnt[ch] ? frame_vals[mod_op] : 0);
        end
        s = sum * 2;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    initial begin
        int k;
        int amp;
        int expected;
        reset          = 1'b0;
        ryt            = 1'b0;
        sample_ready   = 1'b0;
        ops_done_pulse = 1'b0;
        operator_out   = '0;
        opl2_reg_wr    = '0;
        clear_frame();
        foreach (model_cnt[i]) model_cnt[i] = 1'b0;

        repeat (3) @(negedge clk);
        check("reset sample", sample, 0);
        check("reset valid", sample_valid, 0);
        check("reset overrun", overrun, 0);
        reset = 1'b1;
        @(negedge clk);

        drive_op(3, 1000);
        finish_frame("carrier only", 2000);

        write_reg(8'hC0, 8'h01);
        drive_op(0, 1000);
        drive_op(3, -300);
        finish_frame("additive ch0", 1400);
        write_reg(8'hC0, 8'h00);
        drive_op(0, 1000);
        drive_op(3, -300);
        finish_frame("fm ch0", -600);

        write_reg(8'hC8, 8'h01);
        drive_op(14, 100);
        drive_op(17, -50);
        finish_frame("additive ch8", 100);

        ryt = 1'b1;
        drive_op(12, 777);
        drive_op(16, 500);
        finish_frame("rhythm", 2000);
        ryt = 1'b0;

        for (int op = 0; op < 18; op++) if (op % 6 >= 3) drive_op(op, 4095);
        finish_frame("sat high", 32767);
        for (int op = 0; op < 18; op++) if (op % 6 >= 3) drive_op(op, -4096);
        finish_frame("sat low", -32768);

        // Next frame's operators arrive during DRAIN and EMIT.
        drive_op(3, 100);
        pulse_done();
        drive_op(4, 7);
        drive_op(5, 11);
        check("overlap A sample", sample, 200);
        check("overlap A valid", sample_valid, 1);
        sample_ready = 1'b1;
        drive_op(9, 13);
        sample_ready = 1'b0;
        check("overlap A drop", sample_valid, 0);
        finish_frame("overlap B", 62);

        drive_op(3, 5);
        pulse_done();
        wait_valid(k);
        check("ovr f1 latency", k, 3);
        check("ovr f1 sample", sample, 10);
        drive_op(3, 10);
        check("ovr hold sample", sample, 10);
        check("ovr hold valid", sample_valid, 1);
        pulse_done();
        repeat (2) @(negedge clk);
        check("ovr f2 sample", sample, 20);
        check("ovr f2 valid", sample_valid, 1);
        check("ovr flag", overrun, 1);
        sample_ready = 1'b1;
        @(negedge clk);
        sample_ready = 1'b0;
        check("ovr accept drop", sample_valid, 0);
        check("ovr sticky", overrun, 1);

        drive_op(3, 1000);
        operator_out.valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid reset sample", sample, 0);
        check("mid reset valid", sample_valid, 0);
        check("mid reset overrun", overrun, 0);
        @(negedge clk);
        reset = 1'b1;
        foreach (model_cnt[i]) model_cnt[i] = 1'b0;
        @(negedge clk);
        drive_op(4, 50);
        finish_frame("post reset", 100);

        for (int f = 0; f < 25; f++) begin
            repeat ($urandom_range(3)) write_reg(8'hBE + 8'($urandom_range(12)), 8'($urandom_range(255)));
            ryt = 1'($urandom_range(1));
            amp = ($urandom_range(1) != 0) ? 4096 : 600;
            clear_frame();
            for (int op = 0; op < 18; op++) drive_op(op, int'($urandom_range(2 * amp - 1)) - amp);
            expected = model_sample();
            finish_frame($sformatf("random %0d", f), expected);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
